// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the MEM stage and MEM/WB pipeline register.
package mem_stage_pkg;

  localparam int DATA_W     = 64;
  localparam int REG_ADDR_W = 5;
  localparam int WCNT_W     = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/data_memory.sv
// DEPTH x 64-bit data memory with synchronous write and synchronous read.
// A read and a write to the same word on the same edge return the old word.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Hold the previous read word unless a read is requested this cycle.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Write port and read register share one edge, so a same-word read sees the old value.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: doubleword load/store with WAIT_STATES extra
// cycles per access, branch resolution, and stall generation for upstream.
// Optional macro MEM_ALIGN_CHECK_EN enables the sticky misalignment fault.
module mem_wb_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Branch,
  input  logic                  Zero,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic                  MemtoReg,
  input  logic                  RegWrite,
  input  logic [DATA_W-1:0]     Adder_Out_2,
  input  logic [DATA_W-1:0]     Result,
  input  logic [DATA_W-1:0]     Write_Data,
  input  logic [REG_ADDR_W-1:0] RD,
  output logic                  PCSrc,
  output logic [DATA_W-1:0]     Branch_Target,
  output logic                  mem_stall,
  output logic                  MEM_WB_RegWrite,
  output logic                  MEM_WB_MemtoReg,
  output logic [DATA_W-1:0]     MEM_WB_Read_Data,
  output logic [DATA_W-1:0]     MEM_WB_Result,
  output logic [REG_ADDR_W-1:0] MEM_WB_RD,
  output logic                  mem_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam logic HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [WCNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

  mem_state_e            state_q, state_d;
  logic [WCNT_W-1:0]     cnt_q, cnt_d;
  logic                  mem_fault_q, mem_fault_d;
  logic                  load_q, load_d;
  logic                  regwrite_q, regwrite_d;
  logic                  memtoreg_q, memtoreg_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;

  logic                  mem_op;
  logic                  is_load;
  logic                  misaligned;
  logic                  complete;
  logic                  mem_we;
  logic                  mem_re;
  logic [AW-1:0]         word_idx;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  unused_result_bits;

  assign mem_op   = MemRead | MemWrite;
  assign is_load  = MemRead & ~MemWrite;
  assign word_idx = Result[AW+2:3];
  assign unused_result_bits = ^{Result[DATA_W-1:AW+3], Result[2:0]};

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = mem_op & (Result[2:0] != 3'b000);
`else
  assign misaligned = 1'b0;
`endif

  assign PCSrc         = Branch & Zero;
  assign Branch_Target = Adder_Out_2;

  // Access sequencing: decide whether the current access completes this cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!mem_op || !HAS_WAIT) begin
          complete = 1'b1;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_stall = ~complete;
  assign mem_we    = complete & MemWrite & ~misaligned & reset;
  assign mem_re    = complete & is_load & ~misaligned;

  // MEM/WB next values: a bubble while stalled, otherwise pass the EX/MEM controls through.
  always_comb begin
    regwrite_d  = 1'b0;
    memtoreg_d  = 1'b0;
    result_d    = '0;
    rd_d        = '0;
    load_d      = mem_re;
    mem_fault_d = mem_fault_q | (complete & misaligned);
    if (complete) begin
      regwrite_d = RegWrite;
      memtoreg_d = MemtoReg;
      result_d   = Result;
      rd_d       = RD;
    end
  end

  // State, counter, fault flag and MEM/WB register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_fault_q <= 1'b0;
      load_q      <= 1'b0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      result_q    <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_fault_q <= mem_fault_d;
      load_q      <= load_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      result_q    <= result_d;
      rd_q        <= rd_d;
    end
  end

  data_memory #(
    .DEPTH(DEPTH)
  ) u_data_memory (
    .clk  (clk),
    .we   (mem_we),
    .waddr(word_idx),
    .wdata(Write_Data),
    .re   (mem_re),
    .raddr(word_idx),
    .rdata(mem_rdata)
  );

  assign MEM_WB_RegWrite  = regwrite_q;
  assign MEM_WB_MemtoReg  = memtoreg_q;
  assign MEM_WB_Read_Data = load_q ? mem_rdata : '0;
  assign MEM_WB_Result    = result_q;
  assign MEM_WB_RD        = rd_q;
  assign mem_fault        = mem_fault_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: three instances (WAIT_STATES 0, 3, 2) driven by
// directed and random transactions; expected MEM/WB contents are queued per edge
// and compared by a monitor. Honors MEM_ALIGN_CHECK_EN when defined.
module tb_mem_wb_stage;

  localparam int DEPTH = 32;
  localparam int NDUT  = 3;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  function automatic int ws_of(input int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  typedef struct {
    int unsigned at_cycle;
    logic        rw;
    logic        mtr;
    logic [63:0] rdata;
    logic [63:0] result;
    logic [4:0]  rd;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n      [NDUT];
  logic        branch_i     [NDUT];
  logic        zero_i       [NDUT];
  logic        mem_read_i   [NDUT];
  logic        mem_write_i  [NDUT];
  logic        mem_to_reg_i [NDUT];
  logic        reg_write_i  [NDUT];
  logic [63:0] adder_i      [NDUT];
  logic [63:0] result_i     [NDUT];
  logic [63:0] wdata_i      [NDUT];
  logic [4:0]  rd_i         [NDUT];
  logic        pcsrc_o      [NDUT];
  logic [63:0] target_o     [NDUT];
  logic        stall_o      [NDUT];
  logic        wb_rw_o      [NDUT];
  logic        wb_mtr_o     [NDUT];
  logic [63:0] wb_rdata_o   [NDUT];
  logic [63:0] wb_result_o  [NDUT];
  logic [4:0]  wb_rd_o      [NDUT];
  logic        fault_o      [NDUT];

  exp_t        exp_q   [NDUT][$];
  logic [63:0] mdl_mem [NDUT][DEPTH];
  logic        mdl_fault [NDUT];

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_wb_stage #(
      .DEPTH(DEPTH),
      .WAIT_STATES(ws_of(g))
    ) u_dut (
      .clk             (clk),
      .reset           (reset_n[g]),
      .Branch          (branch_i[g]),
      .Zero            (zero_i[g]),
      .MemRead         (mem_read_i[g]),
      .MemWrite        (mem_write_i[g]),
      .MemtoReg        (mem_to_reg_i[g]),
      .RegWrite        (reg_write_i[g]),
      .Adder_Out_2     (adder_i[g]),
      .Result          (result_i[g]),
      .Write_Data      (wdata_i[g]),
      .RD              (rd_i[g]),
      .PCSrc           (pcsrc_o[g]),
      .Branch_Target   (target_o[g]),
      .mem_stall       (stall_o[g]),
      .MEM_WB_RegWrite (wb_rw_o[g]),
      .MEM_WB_MemtoReg (wb_mtr_o[g]),
      .MEM_WB_Read_Data(wb_rdata_o[g]),
      .MEM_WB_Result   (wb_result_o[g]),
      .MEM_WB_RD       (wb_rd_o[g]),
      .mem_fault       (fault_o[g])
    );
  end

  task automatic check_output(input string name, input logic [159:0] act, input logic [159:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic exp_t make_exp(input int unsigned at, input logic rw, input logic mtr,
                                    input logic [63:0] rdata, input logic [63:0] result,
                                    input logic [4:0] rd, input logic fault);
    exp_t e;
    e.at_cycle = at;
    e.rw       = rw;
    e.mtr      = mtr;
    e.rdata    = rdata;
    e.result   = result;
    e.rd       = rd;
    e.fault    = fault;
    return e;
  endfunction

  function automatic logic addr_faults(input logic [63:0] a);
    return ALIGN_EN && ((a % 8) != 0);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Monitor: after each edge, compare the MEM/WB register against every expectation due by now.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      while (exp_q[d].size() > 0 && exp_q[d][0].at_cycle <= cyc) begin
        e = exp_q[d].pop_front();
        check_output($sformatf("dut%0d memwb@%0d", d, e.at_cycle),
                     160'({wb_rw_o[d], wb_mtr_o[d], wb_rdata_o[d], wb_result_o[d], wb_rd_o[d], fault_o[d]}),
                     160'({e.rw, e.mtr, e.rdata, e.result, e.rd, e.fault}));
      end
    end
  end

  task automatic idle(input int d);
    branch_i[d]     = 1'b0;
    zero_i[d]       = 1'b0;
    mem_read_i[d]   = 1'b0;
    mem_write_i[d]  = 1'b0;
    mem_to_reg_i[d] = 1'b0;
    reg_write_i[d]  = 1'b0;
    adder_i[d]      = '0;
    result_i[d]     = '0;
    wdata_i[d]      = '0;
    rd_i[d]         = '0;
  endtask

  // One EX/MEM transaction, held until it completes; called at posedge+1, returns at posedge+1.
  task automatic apply_stimulus(input int d, input logic mr, input logic mw, input logic rw,
                                input logic mtr, input logic [63:0] addr, input logic [63:0] wd,
                                input logic [4:0] rd, input logic br, input logic zr,
                                input logic [63:0] tgt);
    int          nstall;
    int          idx;
    logic        op;
    logic        flt;
    logic [63:0] rdata;
    op     = mr | mw;
    nstall = op ? ws_of(d) : 0;
    flt    = op & addr_faults(addr);
    idx    = int'((addr / 8) % DEPTH);
    mem_read_i[d]   = mr;
    mem_write_i[d]  = mw;
    reg_write_i[d]  = rw;
    mem_to_reg_i[d] = mtr;
    result_i[d]     = addr;
    wdata_i[d]      = wd;
    rd_i[d]         = rd;
    branch_i[d]     = br;
    zero_i[d]       = zr;
    adder_i[d]      = tgt;
    for (int k = 0; k < nstall; k++)
      exp_q[d].push_back(make_exp(cyc + 1 + k, 1'b0, 1'b0, '0, '0, '0, mdl_fault[d]));
    rdata = (mr && !mw && !flt) ? mdl_mem[d][idx] : 64'd0;
    if (mw && !flt) mdl_mem[d][idx] = wd;
    if (flt) mdl_fault[d] = 1'b1;
    exp_q[d].push_back(make_exp(cyc + 1 + nstall, rw, mtr, rdata, addr, rd, mdl_fault[d]));
    for (int k = 0; k <= nstall; k++) begin
      @(negedge clk);
      check_output($sformatf("dut%0d stall c%0d", d, k), 160'(stall_o[d]), 160'(k < nstall));
      check_output($sformatf("dut%0d pcsrc", d), 160'(pcsrc_o[d]), 160'(br & zr));
      check_output($sformatf("dut%0d target", d), 160'(target_o[d]), 160'(tgt));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] a;
    int          kind;
    for (int d = 0; d < NDUT; d++) begin
      idle(d);
      reset_n[d]   = 1'b0;
      mdl_fault[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++)
      exp_q[d].push_back(make_exp(cyc + 1, 1'b0, 1'b0, '0, '0, '0, 1'b0));
    @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) reset_n[d] = 1'b1;

    $display("[TB] filling memories with known contents");
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < DEPTH; w++)
        apply_stimulus(d, 1'b0, 1'b1, 1'($urandom), 1'b0, 64'(w * 8), rand64(), 5'($urandom),
                       1'b0, 1'b0, '0);
      idle(d);
    end

    $display("[TB] directed cases on WAIT_STATES=0 instance");
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h10, 64'hDEADBEEF_CAFEF00D, 5'd0, 1'b0, 1'b0, '0);
    apply_stimulus(0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h10, '0, 5'd5, 1'b0, 1'b0, '0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h7, '0, 5'd31, 1'b0, 1'b0, '0);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 5'd0, 1'b1, 1'b1, 64'h40);
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 5'd0, 1'b1, 1'b0, 64'h40);
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h13, 64'h1111_2222_3333_4444, 5'd0, 1'b0, 1'b0, '0);
    apply_stimulus(0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h10, '0, 5'd6, 1'b0, 1'b0, '0);
    apply_stimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 64'h18, 64'hABCD, 5'd8, 1'b0, 1'b0, '0);
    idle(0);

    $display("[TB] directed cases on WAIT_STATES=3 instance");
    apply_stimulus(1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h28, '0, 5'd7, 1'b1, 1'b1, 64'h80);
    apply_stimulus(1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h28, 64'h0123_4567_89AB_CDEF, 5'd3, 1'b0, 1'b0, '0);
    apply_stimulus(1, 1'b1, 1'b0, 1'b1, 1'b1, 64'h28 + 64'(DEPTH * 8), '0, 5'd4, 1'b0, 1'b0, '0);
    idle(1);

    $display("[TB] reset during an access on WAIT_STATES=2 instance");
    mem_write_i[2] = 1'b1;
    result_i[2]    = 64'h8;
    wdata_i[2]     = 64'h55;
    exp_q[2].push_back(make_exp(cyc + 1, 1'b0, 1'b0, '0, '0, '0, mdl_fault[2]));
    @(negedge clk);
    check_output("dut2 stall before reset c0", 160'(stall_o[2]), 160'(1));
    @(posedge clk);
    #1;
    reset_n[2] = 1'b0;
    idle(2);
    mdl_fault[2] = 1'b0;
    exp_q[2].push_back(make_exp(cyc + 1, 1'b0, 1'b0, '0, '0, '0, 1'b0));
    @(negedge clk);
    check_output("dut2 stall before reset c1", 160'(stall_o[2]), 160'(1));
    @(posedge clk);
    #1;
    reset_n[2] = 1'b1;
    apply_stimulus(2, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 5'd0, 1'b0, 1'b0, '0);
    apply_stimulus(2, 1'b1, 1'b0, 1'b1, 1'b1, 64'h8, '0, 5'd9, 1'b0, 1'b0, '0);
    idle(2);

    $display("[TB] random transactions");
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 40; n++) begin
        a = rand64();
        if ($urandom_range(0, 3) != 0) a[2:0] = 3'b000;
        kind = int'($urandom_range(0, 3));
        apply_stimulus(d, (kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                       1'($urandom), 1'($urandom), a, rand64(), 5'($urandom),
                       1'($urandom), 1'($urandom), rand64());
      end
      idle(d);
    end

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++)
      check_output($sformatf("dut%0d pending expectations", d), 160'(exp_q[d].size()), 160'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
